// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed memory with combinational read data.
// Sub-word stores are handled as a read-modify-write; misaligned or illegal sizes report an error.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic [31:0] Address,
    output logic [31:0] Wdata,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] Rdata
);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, ERR, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, merge_q, load_data_q;
    logic        bad_req;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext_d, merged;
    logic [31:0] word_addr;

    assign word_addr = {addr_q[31:2], 2'b00};

    // Size legality and alignment are judged on the live inputs at acceptance.
    always_comb begin
        bad_req = 1'b0;
        case (funct3)
            3'b000, 3'b100: bad_req = 1'b0;
            3'b001, 3'b101: bad_req = addr[0];
            3'b010:         bad_req = (addr[1:0] != 2'b00);
            default:        bad_req = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req) begin
                if (bad_req)              state_d = ERR;
                else if (!we)             state_d = RD;
                else if (funct3 == 3'b010) state_d = WR;
                else                      state_d = RMW_RD;
            end
            RD:      state_d = DONE;
            WR:      state_d = DONE;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = DONE;
            ERR:     state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_byte = Rdata[7:0];
        case (addr_q[1:0])
            2'd0: rd_byte = Rdata[7:0];
            2'd1: rd_byte = Rdata[15:8];
            2'd2: rd_byte = Rdata[23:16];
            2'd3: rd_byte = Rdata[31:24];
            default: rd_byte = Rdata[7:0];
        endcase
        rd_half = addr_q[1] ? Rdata[31:16] : Rdata[15:0];
        ext_d = Rdata;
        case (funct3_q)
            3'b000:  ext_d = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ext_d = {24'h0, rd_byte};
            3'b001:  ext_d = {{16{rd_half[15]}}, rd_half};
            3'b101:  ext_d = {16'h0, rd_half};
            default: ext_d = Rdata;
        endcase
    end

    // funct3_q[1:0] == 00 selects a byte lane, anything else reaching RMW is a halfword.
    always_comb begin
        merged = merge_q;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = merge_q;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        done       = 1'b0;
        misaligned = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = 32'h0;
        Wdata      = 32'h0;
        case (state_q)
            RD, RMW_RD: begin
                MemRead = 1'b1;
                Address = word_addr;
            end
            WR: begin
                MemWrite = 1'b1;
                Address  = word_addr;
                Wdata    = wdata_q;
            end
            RMW_WR: begin
                MemWrite = 1'b1;
                Address  = word_addr;
                Wdata    = merged;
            end
            ERR: begin
                done       = 1'b1;
                misaligned = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign load_data = load_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            funct3_q    <= 3'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            merge_q     <= 32'h0;
            load_data_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                funct3_q <= funct3;
                addr_q   <= addr;
                wdata_q  <= wdata;
            end
            if (state_q == RD)     load_data_q <= ext_d;
            if (state_q == RMW_RD) merge_q     <= Rdata;
        end
    end

endmodule
